nec_ir_tx: RTL and testbench

NEC infrared transmitter: accepts an 8-bit address and 8-bit command over a valid/ready handshake and emits a complete NEC frame as a carrier-modulated IR drive signal. It is the transmit-side counterpart of the IR demodulator/decoder path. It is used both as an on-chip loopback stimulus source for the receiver chain and to drive an external IR LED. Outputs are fully registered.

---
 rtl/nec_ir_tx.sv | 154 +++++++++++++++
 tb/tb_nec_ir_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises {addr, ~addr, cmd, ~cmd} LSB first as
// pulse-distance coded marks/spaces and gates each mark with a square carrier.
module nec_ir_tx #(
   parameter int unsigned UNIT_CYCLES  = 28125,
   parameter int unsigned CARRIER_HALF = 658,
   parameter int unsigned GAP_UNITS    = 72
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ir_env,
   output logic       ir_out,
   output logic       tx_done
);

   localparam int unsigned MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
   localparam int unsigned UNIT_W    = $clog2(MAX_UNITS);
   localparam int unsigned CYC_W     = $clog2(UNIT_CYCLES);
   localparam int unsigned CAR_W     = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
   localparam logic [CYC_W-1:0]  CYC_PRE  = CYC_W'(UNIT_CYCLES - 2);
   localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'(GAP_UNITS - 1);
   localparam logic [CAR_W-1:0]  CAR_LAST = CAR_W'(CARRIER_HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [CYC_W-1:0]   cyc_cnt;
   logic [UNIT_W-1:0]  unit_cnt;
   logic [UNIT_W-1:0]  units_last;
   logic               state_end;
   logic [4:0]         bit_cnt;
   logic [31:0]        shreg;
   logic [CAR_W-1:0]   car_cnt;
   logic [CAR_W-1:0]   car_cnt_n;
   logic               car_ph;
   logic               car_ph_n;
   logic               mark_n;
   logic               accept;

   assign accept = tx_valid && (state == IDLE);

   // Next-state decode: each state ends on the last cycle of its final unit.
   always_comb begin
      state_n    = state;
      units_last = '0;
      case (state)
         LEAD_MARK:  units_last = UNIT_W'(15);
         LEAD_SPACE: units_last = UNIT_W'(7);
         BIT_SPACE:  units_last = shreg[0] ? UNIT_W'(2) : '0;
         GAP:        units_last = GAP_LAST;
         default:    units_last = '0;
      endcase
      state_end = (cyc_cnt == CYC_LAST) && (unit_cnt == units_last);
      case (state)
         IDLE:       if (accept)    state_n = LEAD_MARK;
         LEAD_MARK:  if (state_end) state_n = LEAD_SPACE;
         LEAD_SPACE: if (state_end) state_n = BIT_MARK;
         BIT_MARK:   if (state_end) state_n = BIT_SPACE;
         BIT_SPACE:  if (state_end) state_n = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  if (state_end) state_n = GAP;
         GAP:        if (state_end) state_n = IDLE;
         default:                   state_n = IDLE;
      endcase
   end

   // Carrier phase for the next cycle; restarts high on entry to any mark.
   always_comb begin
      mark_n    = (state_n == LEAD_MARK) || (state_n == BIT_MARK) || (state_n == STOP_MARK);
      car_cnt_n = '0;
      car_ph_n  = 1'b0;
      if (mark_n && (state_n != state)) begin
         car_cnt_n = '0;
         car_ph_n  = 1'b1;
      end else if (mark_n) begin
         if (car_cnt == CAR_LAST) begin
            car_cnt_n = '0;
            car_ph_n  = ~car_ph;
         end else begin
            car_cnt_n = car_cnt + CAR_W'(1);
            car_ph_n  = car_ph;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Cycle and unit counters, restarted on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt  <= '0;
         unit_cnt <= '0;
      end else if ((state_n != state) || (state == IDLE)) begin
         cyc_cnt  <= '0;
         unit_cnt <= '0;
      end else if (cyc_cnt == CYC_LAST) begin
         cyc_cnt  <= '0;
         unit_cnt <= unit_cnt + UNIT_W'(1);
      end else begin
         cyc_cnt  <= cyc_cnt + CYC_W'(1);
      end
   end

   // Payload capture on accept; shift out one bit per completed bit space.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         shreg   <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
         bit_cnt <= '0;
      end else if ((state == BIT_SPACE) && state_end) begin
         shreg   <= {1'b0, shreg[31:1]};
         bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // Registered outputs; tx_done is raised one cycle early so it lands on the last GAP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_cnt  <= '0;
         car_ph   <= 1'b0;
         ir_env   <= 1'b0;
         ir_out   <= 1'b0;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         car_cnt  <= car_cnt_n;
         car_ph   <= car_ph_n;
         ir_env   <= mark_n;
         ir_out   <= mark_n & car_ph_n;
         tx_ready <= (state_n == IDLE);
         tx_done  <= (state == GAP) && (unit_cnt == GAP_LAST) && (cyc_cnt == CYC_PRE);
      end
   end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboard bench for nec_ir_tx: stimulus queues the expected payload of each
// accepted frame, a monitor decodes the envelope and checks it on tx_done.
module tb_nec_ir_tx;

   localparam int unsigned UC = 4;
   localparam int unsigned CH = 1;
   localparam int unsigned GU = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_addr = '0;
   logic [7:0] tx_cmd = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ir_env;
   logic       ir_out;
   logic       tx_done;

   nec_ir_tx #(
      .UNIT_CYCLES  (UC),
      .CARRIER_HALF (CH),
      .GAP_UNITS    (GU)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_addr  (tx_addr),
      .tx_cmd   (tx_cmd),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .ir_env   (ir_env),
      .ir_out   (ir_out),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] payload;
      int unsigned acc_cyc;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   function automatic void chk(input string name, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, want, want, cyc);
      end
   endfunction

   // Monitor state
   bit          in_frame = 0;
   bit          post_done = 0;
   bit          have_prev = 0;
   logic        cur_lvl = 1'b0;
   int unsigned run_len = 0;
   int unsigned rise_cyc = 0;
   int unsigned fall_cyc = 0;
   int unsigned prev_fall = 0;
   int unsigned car_err = 0;
   int unsigned rdy_err = 0;
   int unsigned idle_err = 0;
   int unsigned frames = 0;
   int unsigned runs[$];

   function automatic void finish_frame();
      exp_t        e;
      logic [31:0] got;
      int unsigned bad;
      int unsigned env_len;
      in_frame  = 0;
      post_done = 1;
      have_prev = 1;
      prev_fall = fall_cyc;
      frames++;
      if (sb.size() == 0) begin
         chk("unexpected_frame", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk("env_rise_cycle", rise_cyc, e.acc_cyc);
      chk("done_after_stop", cyc - fall_cyc, (GU * UC) - 1);
      chk("carrier_errs", car_err, 0);
      chk("ready_low_in_frame", rdy_err, 0);
      chk("run_count", runs.size(), 67);
      if (runs.size() == 67) begin
         chk("lead_mark", runs[0], 64);
         chk("lead_space", runs[1], 32);
         bad = 0;
         got = '0;
         env_len = 0;
         foreach (runs[i]) env_len += runs[i];
         for (int b = 0; b < 32; b++) begin
            if (runs[2 + 2*b] != 4) bad++;
            if (runs[3 + 2*b] == 12) got[b] = 1'b1;
            else if (runs[3 + 2*b] != 4) bad++;
         end
         if (runs[66] != 4) bad++;
         chk("bit_timing_errs", bad, 0);
         chk("payload", got, e.payload);
         chk("env_len", env_len, 484);
      end
   endfunction

   // Monitor: decode the envelope into runs, check carrier and handshake per cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame  = 0;
         post_done = 0;
         have_prev = 0;
         runs.delete();
      end else if (!in_frame) begin
         if (post_done) begin
            chk("ready_after_done", tx_ready, 1);
            chk("done_width", tx_done, 0);
            post_done = 0;
         end
         if (ir_env) begin
            in_frame = 1;
            rise_cyc = cyc;
            cur_lvl  = 1'b1;
            run_len  = 1;
            runs.delete();
            car_err  = (ir_out !== 1'b1) ? 1 : 0;
            rdy_err  = tx_ready ? 1 : 0;
            if (have_prev) begin
               checks++;
               if (cyc - prev_fall < GU * UC + 1) begin
                  errors++;
                  $display("FAIL interframe_space: got %0d cycles expected >= %0d", cyc - prev_fall, GU * UC + 1);
               end
            end
         end else if (ir_out || tx_done) begin
            idle_err++;
         end
      end else begin
         if (ir_env == cur_lvl) run_len++;
         else begin
            runs.push_back(run_len);
            cur_lvl = ir_env;
            run_len = 1;
            if (!ir_env) fall_cyc = cyc;
         end
         if (ir_out !== (ir_env && (((run_len - 1) / CH) % 2 == 0))) car_err++;
         if (tx_ready) rdy_err++;
         if (tx_done) finish_frame();
         else if (runs.size() > 70) begin
            chk("frame_runs", runs.size(), 67);
            in_frame = 0;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] c, input logic [31:0] payload,
                       input bit push, input bit scramble);
      int unsigned n;
      @(negedge clk);
      tx_addr  = a;
      tx_cmd   = c;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         chk("accept_timeout", 0, 1);
         tx_valid = 1'b0;
         return;
      end
      if (push) sb.push_back('{payload, cyc + 1});
      @(negedge clk);
      tx_valid = 1'b0;
      if (scramble) begin
         tx_addr = 8'($urandom);
         tx_cmd  = 8'($urandom);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      int unsigned acc;
      int unsigned falls;
      logic        prev;

      // Reset values while held
      repeat (3) @(negedge clk);
      chk("reset_outputs", {tx_ready, ir_env, ir_out, tx_done}, 4'b1000);
      rst_n = 1'b1;

      // Idle 50 cycles
      repeat (50) begin
         @(negedge clk);
         chk("idle_outputs", {tx_ready, ir_env, ir_out, tx_done}, 4'b1000);
      end

      // Basic frame
      send(8'h00, 8'h80, 32'h7F80_FF00, 1, 0);
      chk("accept_response", {tx_ready, ir_env, ir_out}, 3'b011);

      // Inputs scrambled after accept; tx_valid pulses mid-frame must be ignored
      send(8'h5A, 8'hC3, 32'h3CC3_A55A, 1, 1);
      repeat (150) begin
         @(negedge clk);
         tx_addr  = 8'($urandom);
         tx_cmd   = 8'($urandom);
         tx_valid = 1'($urandom);
      end
      tx_valid = 1'b0;

      // tx_valid held across two frames
      @(negedge clk);
      tx_addr  = 8'h3C;
      tx_cmd   = 8'h96;
      tx_valid = 1'b1;
      acc = 0;
      n = 0;
      while (acc < 2 && n < 3000) begin
         if (tx_ready) begin
            sb.push_back('{32'h6996_C33C, cyc + 1});
            acc++;
         end
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      chk("hold_two_accepts", acc, 2);

      // Reset in the 10th bit space, then a clean frame
      send(8'h00, 8'h12, 32'h0, 0, 0);
      prev  = ir_env;
      falls = 0;
      n = 0;
      while (falls < 11 && n < 1000) begin
         @(negedge clk);
         if (prev && !ir_env) falls++;
         prev = ir_env;
         n++;
      end
      chk("reach_bit9_space", falls, 11);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {tx_ready, ir_env, ir_out, tx_done}, 4'b1000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {tx_ready, ir_env, ir_out, tx_done}, 4'b1000);
      send(8'hA1, 8'h4E, 32'hB14E_5EA1, 1, 0);

      // Back-to-back frames
      send(8'h00, 8'h00, 32'hFF00_FF00, 1, 0);
      send(8'h00, 8'hFF, 32'h00FF_FF00, 1, 0);

      // Drain
      n = 0;
      while ((sb.size() != 0 || in_frame) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
      repeat (20) @(negedge clk);
      chk("frames_seen", frames, 7);
      chk("idle_glitches", idle_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
